// File: rtl/ex_mem_branch_stage_if.sv
// Bundle between the EX stage and the EX/MEM boundary: EX-side inputs,
// registered MEM-side outputs and the PC redirect.
interface ex_mem_branch_stage_if;
    logic        stall;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_sign;
    logic        alu_sltu;
    logic [3:0]  branch_ctrl;
    logic [31:0] target_in;
    logic [31:0] pc_plus4;
    logic [31:0] store_data_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;

    logic        mem_valid;
    logic [31:0] mem_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [2:0]  mem_funct3;
    logic        mem_sign;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Upstream side: drives EX values, observes MEM values and redirect.
    modport master (
        output stall, ex_valid, alu_result, alu_zero, alu_sign, alu_sltu,
               branch_ctrl, target_in, pc_plus4, store_data_in, rd_in,
               reg_write_in, mem_read_in, mem_write_in, funct3_in,
        input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, mem_funct3, mem_sign,
               redirect, redirect_pc
    );

    // Stage side: consumes EX values, produces the registered outputs.
    modport slave (
        input  stall, ex_valid, alu_result, alu_zero, alu_sign, alu_sltu,
               branch_ctrl, target_in, pc_plus4, store_data_in, rd_in,
               reg_write_in, mem_read_in, mem_write_in, funct3_in,
        output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, mem_funct3, mem_sign,
               redirect, redirect_pc
    );
endinterface

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch/jump resolution, a one-cycle PC
// redirect pulse and squashing of the single wrong-path instruction that
// follows a taken control transfer.
module ex_mem_branch_stage (
    input  logic                  clk,
    input  logic                  reset,
    ex_mem_branch_stage_if.slave  bus
);
    logic        kill_reg;
    logic        taken;
    logic        is_jump;
    logic        live;
    logic        accept_taken;
    logic [31:0] target;

    // Resolve the transfer from the ALU flags; the decoder already chose the
    // ALU operation (XOR for EQ/NE, SLT for LT/GE, SLTU for LTU/GEU), so
    // ZERO alone tells us the SLT outcome.
    always_comb begin
        taken   = 1'b0;
        is_jump = 1'b0;
        if (bus.branch_ctrl[3]) begin
            case (bus.branch_ctrl[2:0])
                3'b000: taken = bus.alu_zero;          // BEQ
                3'b001: taken = ~bus.alu_zero;         // BNE
                3'b100: taken = ~bus.alu_zero;         // BLT
                3'b101: taken = bus.alu_zero;          // BGE
                3'b110: taken = bus.alu_sltu;          // BLTU
                3'b111: taken = ~bus.alu_sltu;         // BGEU
                3'b010, 3'b011: begin                  // JAL, JALR
                    taken   = 1'b1;
                    is_jump = 1'b1;
                end
                default: taken = 1'b0;
            endcase
        end
    end

    // JALR clears bit 0 of the computed address; everything else uses the
    // branch adder output.
    assign target = (bus.branch_ctrl == 4'b1011) ? {bus.alu_result[31:1], 1'b0}
                                                 : bus.target_in;

    // The instruction right after an accepted taken transfer is wrong-path.
    assign live         = bus.ex_valid & ~kill_reg;
    assign accept_taken = live & taken;

    // Pipeline register, kill flag and redirect pulse; redirect always drops
    // on the following edge even if the stage is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_reg           <= 1'b0;
            bus.mem_valid      <= 1'b0;
            bus.mem_result     <= 32'd0;
            bus.mem_store_data <= 32'd0;
            bus.mem_rd         <= 5'd0;
            bus.mem_reg_write  <= 1'b0;
            bus.mem_mem_read   <= 1'b0;
            bus.mem_mem_write  <= 1'b0;
            bus.mem_funct3     <= 3'd0;
            bus.mem_sign       <= 1'b0;
            bus.redirect       <= 1'b0;
            bus.redirect_pc    <= 32'd0;
        end else begin
            bus.redirect <= 1'b0;
            if (!bus.stall) begin
                kill_reg           <= accept_taken;
                bus.mem_valid      <= live;
                bus.mem_result     <= is_jump ? bus.pc_plus4 : bus.alu_result;
                bus.mem_store_data <= bus.store_data_in;
                bus.mem_rd         <= bus.rd_in;
                bus.mem_reg_write  <= live & bus.reg_write_in;
                bus.mem_mem_read   <= live & bus.mem_read_in;
                bus.mem_mem_write  <= live & bus.mem_write_in;
                bus.mem_funct3     <= bus.funct3_in;
                bus.mem_sign       <= bus.alu_sign;
                if (accept_taken) begin
                    bus.redirect    <= 1'b1;
                    bus.redirect_pc <= target;
                end
            end
        end
    end
endmodule

// File: doc/ex_mem_branch_stage.md
# ex_mem_branch_stage

EX/MEM boundary stage of the RV32IM pipeline. It sits directly downstream of the integer ALU and consumes its RESULT, ZERO, SIGN_BIT and SLTU_BIT outputs. It resolves conditional branches and jumps, registers the EX results into the EX/MEM pipeline register, and issues a one-cycle PC redirect. It also squashes the single wrong-path instruction that follows a taken control transfer.

## Interface
- No parameters.
- CLK  input  1  pipeline clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- STALL  input  1  MEM stage busy: EX/MEM register holds and no instruction is accepted.
- EX_VALID  input  1  instruction present in EX.
- ALU_RESULT  input  32  ALU RESULT.
- ALU_ZERO  input  1  ALU ZERO flag.
- ALU_SIGN  input  1  ALU SIGN_BIT; registered into MEM_SIGN only, unused for resolution.
- ALU_SLTU  input  1  ALU SLTU_BIT.
- BRANCH_CTRL  input  4  0xxx none; 1000 BEQ, 1001 BNE, 1100 BLT, 1101 BGE, 1110 BLTU, 1111 BGEU, 1010 JAL, 1011 JALR.
- TARGET_IN  input  32  PC+imm from the branch adder.
- PC_PLUS4  input  32  link value.
- STORE_DATA_IN  input  32  rs2 value.
- RD_IN  input  5  destination register.
- REG_WRITE_IN, MEM_READ_IN, MEM_WRITE_IN  input  1 each  control bits.
- FUNCT3_IN  input  3  memory access size/sign.
- MEM_VALID  output  1  EX/MEM register holds a live instruction.
- MEM_RESULT  output  32  ALU_RESULT, or PC_PLUS4 for JAL/JALR.
- MEM_STORE_DATA  output  32  registered STORE_DATA_IN.
- MEM_RD  output  5  registered RD_IN.
- MEM_REG_WRITE, MEM_MEM_READ, MEM_MEM_WRITE  output  1 each  registered controls, forced 0 when the stage is a bubble.
- MEM_FUNCT3  output  3  registered FUNCT3_IN.
- MEM_SIGN  output  1  registered ALU_SIGN.
- REDIRECT  output  1  one-cycle pulse that loads REDIRECT_PC into the PC and flushes IF/ID.
- REDIRECT_PC  output  32  redirect target.

## Operation
- Operand selection is decided by the decoder:
  - BEQ/BNE use ALU_OP XOR.
  - BLT/BGE use SLT.
  - BLTU/BGEU use SLTU.
- Taken conditions:
  - BEQ: ALU_ZERO.
  - BNE: !ALU_ZERO.
  - BLT: !ALU_ZERO (SLT result is 1).
  - BGE: ALU_ZERO.
  - BLTU: ALU_SLTU.
  - BGEU: !ALU_SLTU.
  - JAL/JALR: always taken.
- Target: JALR uses {ALU_RESULT[31:1],1'b0}. All other transfers use TARGET_IN.
- Accept: an instruction is accepted when STALL=0. If EX_VALID=0 or the kill flag is set, it is accepted as a bubble: MEM_VALID=0, all write/mem controls 0, no redirect.
- Kill flag:
  - Set on the edge that accepts a live taken transfer.
  - Cleared on the next accepting edge, which consumes and squashes exactly one instruction.
  - Persists across STALL cycles.
- Stall: when STALL=1, every MEM_* output holds and the kill flag holds.
- REDIRECT:
  - Set to 1 on the edge that accepts a live taken transfer; cleared on the next edge regardless of STALL, so the pulse is never longer than 1 cycle.
  - REDIRECT_PC is loaded on that same edge and holds until the next redirect.
- Non-taken branch: accepted as a live instruction with REG_WRITE, MEM_READ and MEM_WRITE forced to 0 by the decoder. This block passes them through unchanged.

## Timing
- Reset values: MEM_VALID=0, MEM_RESULT=0, MEM_STORE_DATA=0, MEM_RD=0, all control outputs 0, MEM_FUNCT3=0, MEM_SIGN=0, REDIRECT=0, REDIRECT_PC=0, kill flag clear.
- RESET asserted mid-operation clears everything immediately (asynchronously), including a pending kill and an in-flight REDIRECT pulse.
- Latency: 1 cycle from EX inputs to MEM_* outputs and to REDIRECT.
- Back-to-back taken transfers are impossible: the second one is always squashed by the kill flag.
- A taken transfer presented while STALL=1 is not accepted, so no redirect is issued until STALL drops. Its inputs must be held by upstream.

## Test plan
- BEQ with ALU_ZERO=1, TARGET_IN=0x100, STALL=0 -> next cycle REDIRECT=1, REDIRECT_PC=0x100, MEM_VALID=1. The following accepted instruction shows MEM_VALID=0 and MEM_REG_WRITE=0.
- BGEU with ALU_SLTU=1 -> no REDIRECT. The next instruction (ADD, rd=5, RESULT=7) appears with MEM_VALID=1, MEM_RD=5, MEM_RESULT=7.
- JALR with ALU_RESULT=0x203, PC_PLUS4=0x44 -> REDIRECT_PC=0x202, MEM_RESULT=0x44, MEM_REG_WRITE=1.
- JAL accepted, then STALL=1 for 3 cycles -> REDIRECT high for exactly 1 cycle. The first instruction accepted after STALL drops is squashed; the second is live.
- RESET pulsed mid-stall with the kill flag set -> all outputs 0 at once. The first instruction after reset (EX_VALID=1) is live, not squashed.
- STALL=1 with EX_VALID toggling -> MEM_* outputs unchanged for every stalled cycle.
